// File: rtl/pirdsp_pkg.sv
// -----------------------------------------------------------------------------
// pirdsp_pkg
//   Shared definitions for the PIRDSP slice: datapath widths and the USE_SIMD
//   mode encoding seen by the ALU and the P-register stage.
//
//   Contents:
//     PIRDSP_P_WIDTH  - width of S / P / PATTERN / MASK (45)
//     PIRDSP_CARRY_W  - SIMD carry bus width, 2 bits x 8 ALU segments (16)
//     use_simd_e      - USE_SIMD mode encoding
//     simd_lanes()    - number of parallel lanes implied by a USE_SIMD mode
// -----------------------------------------------------------------------------
package pirdsp_pkg;

  localparam int PIRDSP_P_WIDTH = 45;
  localparam int PIRDSP_CARRY_W = 16;

  typedef enum logic [1:0] {
    mode_27x18   = 2'b00,
    mode_sum_9x9 = 2'b01,
    mode_sum_4x4 = 2'b10,
    mode_sum_2x2 = 2'b11
  } use_simd_e;

  // Lane count per mode; handy for downstream unpacking of P. The P stage
  // itself never looks at it because detection always spans the full word.
  function automatic int simd_lanes(input use_simd_e mode);
    case (mode)
      mode_27x18:   return 1;
      mode_sum_9x9: return 2;
      mode_sum_4x4: return 4;
      default:      return 8;
    endcase
  endfunction

endpackage

// File: rtl/pirdsp_pattern_compare.sv
// -----------------------------------------------------------------------------
// pirdsp_pattern_compare
//   Purely combinational masked compare of the ALU result against a pattern
//   and against the pattern's complement.
//
//   Ports:
//     S       in  WIDTH  ALU result
//     PATTERN in  WIDTH  compare pattern
//     MASK    in  WIDTH  1 = bit ignored in both compares
//     pd      out 1      (S & ~MASK) == (PATTERN & ~MASK)
//     pdb     out 1      (S & ~MASK) == (~PATTERN & ~MASK)
// -----------------------------------------------------------------------------
module pirdsp_pattern_compare
  import pirdsp_pkg::*;
#(
  parameter int WIDTH = PIRDSP_P_WIDTH
) (
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [WIDTH-1:0] MASK,
  output logic             pd,
  output logic             pdb
);

  logic [WIDTH-1:0] bit_match;
  logic [WIDTH-1:0] bit_match_bar;

  // Per-bit match: a masked bit always matches. For the complement compare an
  // unmasked bit matches when S differs from PATTERN.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_match[gi]     = MASK[gi] | (S[gi] ~^ PATTERN[gi]);
      assign bit_match_bar[gi] = MASK[gi] | (S[gi] ^ PATTERN[gi]);
    end
  endgenerate

  assign pd  = &bit_match;
  assign pdb = &bit_match_bar;

endmodule

// File: rtl/pirdsp_p_register_pattern_detect.sv
// -----------------------------------------------------------------------------
// pirdsp_p_register_pattern_detect
//   Output stage after the PIRDSP 45-bit SIMD ALU. Registers S into P together
//   with the 16 segment carries and the USE_SIMD mode, registers the masked
//   pattern / pattern-bar detects, and derives OVERFLOW / UNDERFLOW from a
//   one-deep history of those detects. P feeds the accumulate path.
//
//   Ports:
//     clk                  in  1        rising-edge clock
//     reset                in  1        synchronous active-high, overrides CEP
//     CEP                  in  1        clock enable for every register here
//     USE_SIMD             in  2        SIMD mode, carried alongside P
//     S                    in  WIDTH    ALU result
//     result_SIMD_carry_in in  CARRY_W  ALU segment carries
//     PATTERN              in  WIDTH    compare pattern
//     MASK                 in  WIDTH    1 = bit ignored in compare
//     P                    out WIDTH    registered result
//     CARRY_Q              out CARRY_W  registered segment carries
//     USE_SIMD_Q           out 2        USE_SIMD aligned with P
//     PATTERNDETECT        out 1        registered pattern match
//     PATTERNBDETECT       out 1        registered pattern-bar match
//     OVERFLOW             out 1        previous PD, now neither PD nor PDB
//     UNDERFLOW            out 1        previous PDB, now neither PD nor PDB
//
//   Build option:
//     PIRDSP_AUTORESET_PATDET_EN - when defined, a CEP edge that sees a
//       registered PATTERNDETECT clears P, CARRY_Q and both detects instead of
//       loading them (terminal-count accumulators). The detect history still
//       loads so the terminal match is remembered.
// -----------------------------------------------------------------------------
module pirdsp_p_register_pattern_detect
  import pirdsp_pkg::*;
#(
  parameter int WIDTH   = PIRDSP_P_WIDTH,
  parameter int CARRY_W = PIRDSP_CARRY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CEP,
  input  logic [1:0]         USE_SIMD,
  input  logic [WIDTH-1:0]   S,
  input  logic [CARRY_W-1:0] result_SIMD_carry_in,
  input  logic [WIDTH-1:0]   PATTERN,
  input  logic [WIDTH-1:0]   MASK,
  output logic [WIDTH-1:0]   P,
  output logic [CARRY_W-1:0] CARRY_Q,
  output logic [1:0]         USE_SIMD_Q,
  output logic               PATTERNDETECT,
  output logic               PATTERNBDETECT,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  logic               pd_next;
  logic               pdb_next;
  logic               autoreset_hit;

  logic [WIDTH-1:0]   p_reg;
  logic [CARRY_W-1:0] carry_reg;
  use_simd_e          simd_reg;
  logic               pd_reg;
  logic               pdb_reg;
  logic               pd_past_reg;
  logic               pdb_past_reg;

  pirdsp_pattern_compare #(
    .WIDTH (WIDTH)
  ) u_compare (
    .S       (S),
    .PATTERN (PATTERN),
    .MASK    (MASK),
    .pd      (pd_next),
    .pdb     (pdb_next)
  );

`ifdef PIRDSP_AUTORESET_PATDET_EN
  // Autoreset keys off the registered detect, i.e. the match seen last edge.
  assign autoreset_hit = pd_reg;
`else
  assign autoreset_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg        <= '0;
      carry_reg    <= '0;
      simd_reg     <= mode_27x18;
      pd_reg       <= 1'b0;
      pdb_reg      <= 1'b0;
      pd_past_reg  <= 1'b0;
      pdb_past_reg <= 1'b0;
    end else if (CEP) begin
      // History always captures the detects as they stood before this edge,
      // including the terminal match that triggers an autoreset.
      pd_past_reg  <= pd_reg;
      pdb_past_reg <= pdb_reg;
      simd_reg     <= use_simd_e'(USE_SIMD);
      if (autoreset_hit) begin
        p_reg     <= '0;
        carry_reg <= '0;
        pd_reg    <= 1'b0;
        pdb_reg   <= 1'b0;
      end else begin
        p_reg     <= S;
        carry_reg <= result_SIMD_carry_in;
        pd_reg    <= pd_next;
        pdb_reg   <= pdb_next;
      end
    end
  end

  assign P              = p_reg;
  assign CARRY_Q        = carry_reg;
  assign USE_SIMD_Q     = simd_reg;
  assign PATTERNDETECT  = pd_reg;
  assign PATTERNBDETECT = pdb_reg;

  // Built only from flops, so no input glitch can reach these flags.
  assign OVERFLOW  = pd_past_reg  & ~pd_reg & ~pdb_reg;
  assign UNDERFLOW = pdb_past_reg & ~pd_reg & ~pdb_reg;

endmodule

// File: tb/tb_pirdsp_p_register_pattern_detect.sv
module tb_pirdsp_p_register_pattern_detect;

  logic        clk;
  logic        reset;
  logic        CEP;
  logic [1:0]  USE_SIMD;
  logic [44:0] S;
  logic [15:0] result_SIMD_carry_in;
  logic [44:0] PATTERN;
  logic [44:0] MASK;
  logic [44:0] P;
  logic [15:0] CARRY_Q;
  logic [1:0]  USE_SIMD_Q;
  logic        PATTERNDETECT;
  logic        PATTERNBDETECT;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  pirdsp_p_register_pattern_detect dut (
    .clk                  (clk),
    .reset                (reset),
    .CEP                  (CEP),
    .USE_SIMD             (USE_SIMD),
    .S                    (S),
    .result_SIMD_carry_in (result_SIMD_carry_in),
    .PATTERN              (PATTERN),
    .MASK                 (MASK),
    .P                    (P),
    .CARRY_Q              (CARRY_Q),
    .USE_SIMD_Q           (USE_SIMD_Q),
    .PATTERNDETECT        (PATTERNDETECT),
    .PATTERNBDETECT       (PATTERNBDETECT),
    .OVERFLOW             (OVERFLOW),
    .UNDERFLOW            (UNDERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [44:0] p;
    logic [15:0] c;
    logic [1:0]  u;
    logic        pd;
    logic        pdb;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    txn    = 0;

`ifdef PIRDSP_AUTORESET_PATDET_EN
  localparam bit AUTORESET = 1'b1;
`else
  localparam bit AUTORESET = 1'b0;
`endif

  // Reference state: what the block should be holding after each edge.
  logic [44:0] m_p;
  logic [15:0] m_c;
  logic [1:0]  m_u;
  bit          m_pd, m_pdb, m_hist_pd, m_hist_pdb;

  task automatic model_edge(input bit rst, input bit cep, input logic [1:0] simd,
                            input logic [44:0] s, input logic [15:0] carry,
                            input logic [44:0] pat, input logic [44:0] mask);
    bit match_now, matchb_now, terminal;
    match_now  = ((s & ~mask) == (pat & ~mask));
    matchb_now = ((s & ~mask) == (~pat & ~mask));
    terminal   = AUTORESET && m_pd;
    if (rst) begin
      m_p = '0; m_c = '0; m_u = 2'b00;
      m_pd = 0; m_pdb = 0; m_hist_pd = 0; m_hist_pdb = 0;
    end else if (cep) begin
      m_hist_pd  = m_pd;
      m_hist_pdb = m_pdb;
      m_u        = simd;
      if (terminal) begin
        m_p = '0; m_c = '0; m_pd = 0; m_pdb = 0;
      end else begin
        m_p = s; m_c = carry; m_pd = match_now; m_pdb = matchb_now;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit cep, input logic [1:0] simd,
                       input logic [44:0] s, input logic [15:0] carry,
                       input logic [44:0] pat, input logic [44:0] mask,
                       input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst; CEP = cep; USE_SIMD = simd; S = s;
    result_SIMD_carry_in = carry; PATTERN = pat; MASK = mask;
    model_edge(rst, cep, simd, s, carry, pat, mask);
    e.p   = m_p;
    e.c   = m_c;
    e.u   = m_u;
    e.pd  = m_pd;
    e.pdb = m_pdb;
    e.ovf = m_hist_pd  && !m_pd && !m_pdb;
    e.unf = m_hist_pdb && !m_pd && !m_pdb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: every edge presents a new output state; compare it to the oldest
  // queued expectation.
  initial begin
    exp_t  e, a;
    string tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        a.p = P; a.c = CARRY_Q; a.u = USE_SIMD_Q; a.pd = PATTERNDETECT;
        a.pdb = PATTERNBDETECT; a.ovf = OVERFLOW; a.unf = UNDERFLOW;
        checks++;
        txn++;
        if (a !== e) begin
          errors++;
          $display("FAIL txn %0d %s: got P=%h C=%h U=%b pd=%b pdb=%b ovf=%b unf=%b, want P=%h C=%h U=%b pd=%b pdb=%b ovf=%b unf=%b",
                   txn, tag, a.p, a.c, a.u, a.pd, a.pdb, a.ovf, a.unf,
                   e.p, e.c, e.u, e.pd, e.pdb, e.ovf, e.unf);
        end else begin
          $display("txn %0d %s: P=%h C=%h U=%b pd=%b pdb=%b ovf=%b unf=%b ok",
                   txn, tag, a.p, a.c, a.u, a.pd, a.pdb, a.ovf, a.unf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [44:0] all1, lowbyte_mask, low4_mask, pat, mask, s;
    logic [63:0] r;
    all1         = '1;
    lowbyte_mask = 45'h1FFF_FFFF_FF00;
    low4_mask    = 45'h1FFF_FFFF_FFF0;

    reset = 1'b1; CEP = 1'b0; USE_SIMD = 2'b00; S = '0;
    result_SIMD_carry_in = '0; PATTERN = '0; MASK = '0;

    // Reset overrides CEP, then P follows S one edge after release.
    drive(1, 1, 2'b01, 45'h1FFF_FFFF_FFFF, 16'hFFFF, 45'h0, 45'h0, "reset_hold");
    drive(1, 1, 2'b01, 45'h1FFF_FFFF_FFFF, 16'hFFFF, 45'h0, 45'h0, "reset_hold2");
    drive(0, 1, 2'b01, 45'h1FFF_FFFF_FFFF, 16'h1234, 45'h0, 45'h0, "release_load");

    // CEP=0 holds everything while S keeps moving.
    for (int i = 0; i < 5; i++)
      drive(0, 0, 2'b10, 45'(i * 37 + 5), 16'(i), 45'h0, 45'h0, "cep_hold");

    // Pattern then no-match: one-cycle OVERFLOW.
    drive(0, 1, 2'b00, 45'h000, 16'h0, 45'h0, lowbyte_mask, "ovf_pd");
    drive(0, 1, 2'b00, 45'h100, 16'h0, 45'h0, lowbyte_mask, "ovf_hi_masked");
    drive(0, 1, 2'b00, 45'h001, 16'h0, 45'h0, lowbyte_mask, "ovf_flag");
    drive(0, 1, 2'b00, 45'h002, 16'h0, 45'h0, lowbyte_mask, "ovf_clear");

    // Pattern-bar then no-match: one-cycle UNDERFLOW.
    drive(0, 1, 2'b00, 45'h0FF, 16'h0, 45'h0, lowbyte_mask, "unf_pdb");
    drive(0, 1, 2'b00, 45'h0FE, 16'h0, 45'h0, lowbyte_mask, "unf_flag");
    drive(0, 1, 2'b00, 45'h0FD, 16'h0, 45'h0, lowbyte_mask, "unf_clear");

    // Carry and SIMD mode pass-through.
    drive(0, 1, 2'b11, 45'h123, 16'hA5C3, 45'h0, 45'h0, "carry_simd");

    // All bits masked: both detects set every cycle.
    drive(0, 1, 2'b00, 45'h0ABC_DEF0_1234, 16'h0, 45'h5555, all1, "mask_all1");
    drive(0, 1, 2'b00, 45'h1234, 16'h0, 45'h7777, all1, "mask_all1b");
    drive(0, 1, 2'b00, 45'h0, 16'h0, 45'h0, 45'h0, "mask_all1_exit");

    // Terminal-count accumulator: count 8..12 against PATTERN=10.
    for (int i = 8; i <= 12; i++)
      drive(0, 1, 2'b00, 45'(i), 16'(i), 45'd10, 45'h0, "count");
    drive(0, 1, 2'b00, 45'd13, 16'h0, 45'd10, 45'h0, "count_tail");

    // Reset landing on a would-be autoreset edge clears the history too.
    drive(0, 1, 2'b00, 45'd10, 16'h0, 45'd10, 45'h0, "pre_reset_match");
    drive(1, 1, 2'b00, 45'd11, 16'h0, 45'd10, 45'h0, "reset_on_terminal");
    drive(0, 1, 2'b00, 45'd5, 16'h0, 45'd10, 45'h0, "no_spurious_ovf");

    // Randomized traffic, biased towards near-matches so detects toggle.
    for (int i = 0; i < 300; i++) begin
      r = {$urandom, $urandom};
      pat = r[44:0];
      case ($urandom_range(0, 3))
        0: begin r = {$urandom, $urandom}; mask = r[44:0]; end
        1: mask = low4_mask;
        2: mask = all1;
        default: mask = '0;
      endcase
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s = pat ^ 45'($urandom_range(0, 15));
        1: s = ~pat ^ 45'($urandom_range(0, 15));
        2: s = pat;
        default: s = r[44:0];
      endcase
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80,
            2'($urandom_range(0, 3)), s, 16'($urandom), pat, mask, "random");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
